// File: rtl/ps2_host_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ps2_host_rx_fifo
// Description : PS/2 host-side receiver. Synchronises and glitch-filters the
//               pad lines, decodes 11-bit device-to-host frames (odd parity,
//               stop bit, inter-edge timeout) and buffers good bytes in a
//               first-word-fall-through FIFO. Inhibits the device by pulling
//               ps2_clk low while disabled or (optionally) while full.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_host_rx_fifo #(
    parameter int unsigned DEPTH_LOG2        = 3,
    parameter int unsigned FILTER_LEN        = 4,
    parameter int unsigned TIMEOUT_BITS      = 10,
    parameter int unsigned INHIBIT_WHEN_FULL = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ps2_clk_i,
    input  logic                  ps2_data_i,
    output logic                  ps2_clk_oe,
    input  logic                  rx_en,
    input  logic                  rd_en,
    output logic [7:0]            rd_data,
    output logic                  rd_valid,
    output logic [DEPTH_LOG2:0]   rd_count,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  overflow,
    input  logic                  err_clr
);

    localparam int unsigned         c_DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_FULL      = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [3:0]          c_FILT_LAST = 4'(FILTER_LEN - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;
    localparam logic [1:0] S_STOP   = 2'd3;

    // Input conditioning
    logic [1:0]              sync_clk_q, sync_clk_d;
    logic [1:0]              sync_dat_q, sync_dat_d;
    logic                    filt_clk_q, filt_clk_d;
    logic [3:0]              filt_cnt_q, filt_cnt_d;
    logic                    w_edge;
    logic                    w_din;

    // Frame decoder
    logic [1:0]              state_q, state_d;
    logic [2:0]              bit_cnt_q, bit_cnt_d;
    logic [7:0]              shift_q, shift_d;
    logic                    par_q, par_d;
    logic [TIMEOUT_BITS-1:0] tmo_q, tmo_d;
    logic                    w_push;
    logic                    w_perr;
    logic                    w_ferr;

    // FIFO and status
    logic [7:0]              mem_q [c_DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]     count_q, count_d;
    logic                    overflow_q, overflow_d;
    logic                    perr_q, ferr_q;
    logic                    oe_q, oe_d;
    logic                    w_full;
    logic                    w_pop;
    logic                    w_wr;

    // Two-flop synchronisers and the clock-line glitch filter
    always_comb begin
        sync_clk_d = {sync_clk_q[0], ps2_clk_i};
        sync_dat_d = {sync_dat_q[0], ps2_data_i};
        filt_clk_d = filt_clk_q;
        filt_cnt_d = '0;
        if (sync_clk_q[1] != filt_clk_q) begin
            if (filt_cnt_q == c_FILT_LAST) begin
                filt_clk_d = ~filt_clk_q;
            end else begin
                filt_cnt_d = filt_cnt_q + 4'd1;
            end
        end
    end

    // The edge cycle is the one in which the filtered clock falls
    assign w_edge = filt_clk_q & ~filt_clk_d;
    assign w_din  = sync_dat_q[1];

    // Frame decoder: start, 8 data bits LSB first, parity, stop, timeout
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        tmo_d     = tmo_q;
        w_push    = 1'b0;
        w_perr    = 1'b0;
        w_ferr    = 1'b0;
        if (!rx_en) begin
            // Disable silently abandons whatever frame was in flight
            state_d = S_IDLE;
            tmo_d   = '0;
        end else if (state_q == S_IDLE) begin
            if (w_edge && !w_din) begin
                state_d   = S_DATA;
                bit_cnt_d = 3'd0;
                tmo_d     = '0;
            end
        end else if (w_edge) begin
            tmo_d = '0;
            if (state_q == S_DATA) begin
                shift_d   = {w_din, shift_q[7:1]};
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    state_d = S_PARITY;
                end
            end else if (state_q == S_PARITY) begin
                par_d   = w_din;
                state_d = S_STOP;
            end else begin
                // Parity failure takes precedence over a bad stop bit
                state_d = S_IDLE;
                if (!(^{shift_q, par_q})) begin
                    w_perr = 1'b1;
                end else if (!w_din) begin
                    w_ferr = 1'b1;
                end else begin
                    w_push = 1'b1;
                end
            end
        end else if (&tmo_q) begin
            w_ferr  = 1'b1;
            state_d = S_IDLE;
            tmo_d   = '0;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    // FIFO pointer/count bookkeeping, overflow flag and inhibit request
    always_comb begin
        w_full   = (count_q == c_FULL);
        w_pop    = rd_en & (count_q != '0);
        // A push into a full FIFO still lands if the head leaves this cycle
        w_wr     = w_push & (~w_full | w_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_wr) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (w_wr && !w_pop) begin
            count_d = count_q + 1'b1;
        end else if (!w_wr && w_pop) begin
            count_d = count_q - 1'b1;
        end
        overflow_d = err_clr ? 1'b0 : (overflow_q | (w_push & w_full & ~w_pop));
        oe_d       = ~rx_en | ((INHIBIT_WHEN_FULL != 0) & w_full & (state_q == S_IDLE));
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_clk_q <= 2'b11;
            sync_dat_q <= 2'b11;
            filt_clk_q <= 1'b1;
            filt_cnt_q <= '0;
            state_q    <= S_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            tmo_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            oe_q       <= 1'b0;
        end else begin
            sync_clk_q <= sync_clk_d;
            sync_dat_q <= sync_dat_d;
            filt_clk_q <= filt_clk_d;
            filt_cnt_q <= filt_cnt_d;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            tmo_q      <= tmo_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            perr_q     <= w_perr;
            ferr_q     <= w_ferr;
            oe_q       <= oe_d;
        end
    end

    // Storage array; contents are don't-care until a pointer covers them
    always_ff @(posedge clk) begin
        if (!rst && w_wr) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    assign rd_valid   = (count_q != '0);
    assign rd_data    = rd_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign rd_count   = count_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign overflow   = overflow_q;
    assign ps2_clk_oe = oe_q;

endmodule
`default_nettype wire
